// File: rtl/line_window_buf_pkg.sv
// Shared defaults and helpers for the sliding-window line buffer.
package line_window_buf_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_IMAGE_WIDTH  = 640;
  localparam int DEF_IMAGE_HEIGHT = 480;
  localparam int DEF_KSIZE        = 7;

  // Bits needed to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_window_buf_fifo.sv
// Enable-gated fixed delay line: output is the input pushed DEPTH enabled pushes earlier.
// Built as DEPTH-1 RAM entries plus a read-first output register so it maps onto block RAM.
module line_fifo
  import line_window_buf_pkg::*;
#(
  parameter int DEPTH = DEF_IMAGE_WIDTH - DEF_KSIZE,
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] rd_q;

  assign dout = rd_q;

  generate
    if (DEPTH == 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (en) rd_q <= din;
      end
    end else begin : g_ram
      localparam int ENTRIES = DEPTH - 1;
      localparam int PTR_W   = cnt_width(ENTRIES);

      logic [WIDTH-1:0] mem [ENTRIES];
      logic [PTR_W-1:0] ptr_q, ptr_d;

      always_comb begin
        ptr_d = ptr_q;
        if (en) ptr_d = (ptr_q == PTR_W'(ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
      end

      // NOTE: the RAM and its read register have no reset so they stay BRAM-inferable;
      // stale contents are masked by the window-valid and dout fill logic upstream.
      always_ff @(posedge clk) begin
        if (en) begin
          rd_q         <= mem[ptr_q];
          mem[ptr_q]   <= din;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/line_window_buf.sv
// KSIZE x KSIZE sliding window over a raster pixel stream, with frame coordinates,
// a window-valid flag and a cascade output delayed by KSIZE full lines.
module line_window_buf
  import line_window_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int KSIZE        = DEF_KSIZE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                din_valid,
  input  logic [DATA_WIDTH-1:0]               din,
  input  logic                                sof,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   win,
  output logic                                win_valid,
  output logic [cnt_width(IMAGE_WIDTH)-1:0]   col,
  output logic [cnt_width(IMAGE_HEIGHT)-1:0]  row,
  output logic [DATA_WIDTH-1:0]               dout
);

  localparam int COL_W      = cnt_width(IMAGE_WIDTH);
  localparam int ROW_W      = cnt_width(IMAGE_HEIGHT);
  localparam int FIFO_DEPTH = IMAGE_WIDTH - KSIZE;
  localparam int FILL_CNT   = KSIZE * IMAGE_WIDTH;
  localparam int FILL_W     = cnt_width(FILL_CNT + 1);

  logic [DATA_WIDTH-1:0] tap_q [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] tap_d [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] fifo_out [KSIZE];

  logic [COL_W-1:0]      col_q, col_d, pix_col;
  logic [ROW_W-1:0]      row_q, row_d, pix_row;
  logic                  started_q, started_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  win_valid_q, win_valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  accept;

  assign accept = din_valid & ~rst;

  // Coordinate the incoming pixel will take; first pixel after reset or sof is (0,0).
  always_comb begin
    if (sof || !started_q) begin
      pix_col = '0;
      pix_row = '0;
    end else if (col_q == COL_W'(IMAGE_WIDTH - 1)) begin
      pix_col = '0;
      pix_row = (row_q == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : row_q + 1'b1;
    end else begin
      pix_col = col_q + 1'b1;
      pix_row = row_q;
    end
  end

  // NOTE: every signal is given its hold value first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    tap_d       = tap_q;
    col_d       = col_q;
    row_d       = row_q;
    started_d   = started_q;
    fill_d      = fill_q;
    dout_d      = dout_q;
    win_valid_d = 1'b0;
    if (din_valid) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = KSIZE - 1; c > 0; c--) tap_d[r][c] = tap_q[r][c-1];
      end
      tap_d[0][0] = din;
      for (int r = 1; r < KSIZE; r++) tap_d[r][0] = fifo_out[r-1];
      col_d       = pix_col;
      row_d       = pix_row;
      started_d   = 1'b1;
      win_valid_d = (pix_row >= ROW_W'(KSIZE - 1)) && (pix_col >= COL_W'(KSIZE - 1));
      // Cascade output is forced to 0 until KSIZE lines have flowed in since reset.
      dout_d      = (fill_q == FILL_W'(FILL_CNT)) ? fifo_out[KSIZE-1] : '0;
      if (fill_q != FILL_W'(FILL_CNT)) fill_d = fill_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q       <= '{default: '0};
      col_q       <= '0;
      row_q       <= '0;
      started_q   <= 1'b0;
      fill_q      <= '0;
      dout_q      <= '0;
      win_valid_q <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      col_q       <= col_d;
      row_q       <= row_d;
      started_q   <= started_d;
      fill_q      <= fill_d;
      dout_q      <= dout_d;
      win_valid_q <= win_valid_d;
    end
  end

  // Row r delay: KSIZE taps plus this FIFO gives exactly one line into row r+1.
  for (genvar r = 0; r < KSIZE; r++) begin : g_line
    line_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (tap_q[r][KSIZE-1]),
      .dout (fifo_out[r])
    );
  end

  for (genvar r = 0; r < KSIZE; r++) begin : g_win_r
    for (genvar c = 0; c < KSIZE; c++) begin : g_win_c
      assign win[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = tap_q[r][c];
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign win_valid = win_valid_q;
  assign dout      = dout_q;

endmodule

// File: doc/line_window_buf.md
LINE_WINDOW_BUF -- requirements
Module: line_window_buf

Interface
REQ-001 Parameters, one per line (name, default, meaning), SHALL be:
- DATA_WIDTH, 8, pixel width in bits.
- IMAGE_WIDTH, 640, pixels per line.
- IMAGE_HEIGHT, 480, lines per frame.
- KSIZE, 7, window edge; odd, legal range 3..7.
REQ-002 Ports, one per line (name, direction, width, meaning), SHALL be:
- clk, in, 1, the block's one clock.
- rst, in, 1, reset; synchronous, active-high.
- din_valid, in, 1, din and sof are accepted on a rising edge with din_valid=1.
- din, in, DATA_WIDTH, raster-order pixel.
- sof, in, 1, start of frame; qualified by din_valid.
- win, out, KSIZE*KSIZE*DATA_WIDTH, flattened window; tap(r,c) at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH].
- win_valid, out, 1, win holds a complete in-image window.
- col, out, clog2(IMAGE_WIDTH), column of the most recently accepted pixel.
- row, out, clog2(IMAGE_HEIGHT), row of the most recently accepted pixel.
- dout, out, DATA_WIDTH, cascade output of the last line delay.

Function
REQ-003 Every register (taps, line storage, counters) SHALL advance only on an edge with din_valid=1; with din_valid=0, all outputs SHALL hold and win_valid SHALL be 0.
REQ-004 Tap(r,c) SHALL equal the pixel accepted at raster position (row-r, col-c), r,c in 0..KSIZE-1; tap(0,0) is the newest pixel.
REQ-005 Latency: a pixel accepted at edge N SHALL appear in tap(0,0), col and row immediately after edge N (1 cycle).
REQ-006 Each row delay SHALL be exactly IMAGE_WIDTH accepted pixels, implemented as KSIZE tap registers plus an (IMAGE_WIDTH-KSIZE)-deep line FIFO.
REQ-007 dout SHALL equal the pixel accepted KSIZE*IMAGE_WIDTH accepted pixels earlier (0 until filled after reset).
REQ-008 Column wrap: col SHALL count 0..IMAGE_WIDTH-1; at IMAGE_WIDTH-1 it SHALL wrap to 0 and increment row.
REQ-009 Row wrap: row SHALL count 0..IMAGE_HEIGHT-1 and wrap to 0 after IMAGE_HEIGHT-1.
REQ-010 An accepted pixel with sof=1 SHALL be assigned (row,col)=(0,0) regardless of the counter state; line storage SHALL NOT be cleared.
REQ-011 win_valid SHALL be 1 for exactly the cycle following an accepting edge whose pixel has row>=KSIZE-1 and col>=KSIZE-1, and 0 otherwise; windows straddling a line or frame boundary SHALL never be flagged.
REQ-012 Valid windows per frame SHALL total (IMAGE_WIDTH-KSIZE+1)*(IMAGE_HEIGHT-KSIZE+1).
REQ-013 All arithmetic SHALL be unsigned; counters SHALL never exceed their terminal values.

Reset
REQ-014 While rst=1 at an edge, win, win_valid, col, row and dout SHALL become 0 and din_valid SHALL be ignored.
REQ-015 Line FIFO contents SHALL NOT be reset; stale data SHALL be masked by REQ-011 and REQ-007.
REQ-016 After reset, including mid-frame, the first accepted pixel SHALL be coordinate (0,0).

Structure
REQ-017 A shared package SHALL hold default DATA_WIDTH, IMAGE_WIDTH, IMAGE_HEIGHT, KSIZE, and a clog2-based counter-width function.
REQ-018 One sub-module, line_fifo (parametrised depth/width, enable-gated, BRAM-inferable), SHALL be instantiated KSIZE times.

Verification (IMAGE_WIDTH=16, IMAGE_HEIGHT=12, KSIZE=3 unless stated; din=(row*16+col) mod 256)
REQ-019 The bench SHALL cover these directed scenarios:
- Continuous ramp frame -> first win_valid after pixel (2,2); tap(0,0)=34, tap(1,0)=18, tap(2,2)=0.
- Same frame with din_valid 50% random -> identical window sequence; win_valid=0 on all stall cycles.
- Full frame -> exactly 140 win_valid pulses; none while col<2 or row<2.
- sof asserted at pixel (5,7) -> col=0, row=0 next cycle; no win_valid until new (2,2).
- rst for 1 cycle mid-frame -> all outputs 0 next cycle; next pixel is (0,0).
- Defaults (640x480, KSIZE=7) -> dout equals din delayed by 4480 accepted pixels; first win_valid at pixel (6,6).
